// File: rtl/queue_pkg.sv
// ============================================================================
// Module      : queue_pkg
// Description : Width helpers and pointer-wrap function shared by param_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package queue_pkg;

  // Pointer width never drops below one bit, even for a single-entry queue.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps at depth-1 explicitly so non-power-of-two depths work.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_queue_if.sv
// ============================================================================
// Module      : param_queue_if
// Description : Enq/deq ready-valid bundle plus occupancy; io_flush exists only
//               when QUEUE_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_queue_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
);
  import queue_pkg::*;

  localparam int CW = count_width(DEPTH);

  logic             io_enq_valid;
  logic [WIDTH-1:0] io_enq_bits_data;
  logic             io_enq_ready;
  logic             io_deq_ready;
  logic             io_deq_valid;
  logic [WIDTH-1:0] io_deq_bits_data;
  logic [CW-1:0]    io_count;
`ifdef QUEUE_FLUSH_EN
  logic             io_flush;
`endif

  modport master (
`ifdef QUEUE_FLUSH_EN
    output io_flush,
`endif
    output io_enq_valid, io_enq_bits_data, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_bits_data, io_count
  );

  modport slave (
`ifdef QUEUE_FLUSH_EN
    input  io_flush,
`endif
    input  io_enq_valid, io_enq_bits_data, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_bits_data, io_count
  );

endinterface

`default_nettype wire

// File: rtl/queue_ram.sv
// ============================================================================
// Module      : queue_ram
// Description : DEPTH x WIDTH storage, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_ram
  import queue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/param_queue.sv
// ============================================================================
// Module      : param_queue
// Description : Parametrised ready/valid FIFO with optional flow-through bypass,
//               pipe-mode ready and occupancy count. Synchronous flush is
//               compiled in when QUEUE_FLUSH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_queue
  import queue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3,
  parameter bit FLOW  = 1'b0,
  parameter bit PIPE  = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  param_queue_if.slave io
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [PW:0]   DEPTH_P = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
  logic             maybe_full_q, maybe_full_d;

  logic             ptr_match, empty, full;
  logic             enq_ready, deq_valid, do_enq, do_deq, flush;
  logic [WIDTH-1:0] ram_rd_data, deq_data;
  logic [PW:0]      diff;
  logic [CW-1:0]    count;

`ifdef QUEUE_FLUSH_EN
  assign flush = io.io_flush;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    ptr_match = (enq_ptr_q == deq_ptr_q);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match & maybe_full_q;

    enq_ready = PIPE ? (~full | io.io_deq_ready) : ~full;
    deq_valid = FLOW ? (~empty | io.io_enq_valid) : ~empty;
    if (flush) begin
      enq_ready = 1'b0;
      deq_valid = 1'b0;
    end
    deq_data = (FLOW && empty) ? io.io_enq_bits_data : ram_rd_data;

    do_enq = io.io_enq_valid & enq_ready;
    do_deq = io.io_deq_ready & deq_valid;
    // A bypassed beat goes straight through and never touches storage.
    if (FLOW && empty) begin
      do_deq = 1'b0;
      if (io.io_deq_ready) do_enq = 1'b0;
    end
  end

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (flush) begin
      enq_ptr_d    = '0;
      deq_ptr_d    = '0;
      maybe_full_d = 1'b0;
    end else begin
      if (do_enq) enq_ptr_d = PW'(ptr_inc(32'(enq_ptr_q), DEPTH));
      if (do_deq) deq_ptr_d = PW'(ptr_inc(32'(deq_ptr_q), DEPTH));
      if (do_enq != do_deq) maybe_full_d = do_enq;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Occupancy: pointer difference, corrected by DEPTH when it borrows.
  always_comb begin
    diff = {1'b0, enq_ptr_q} - {1'b0, deq_ptr_q};
    if (enq_ptr_q < deq_ptr_q) diff = diff + DEPTH_P;
    if (full)       count = DEPTH_C;
    else if (empty) count = '0;
    else            count = CW'(diff);
  end

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk_i     (clock),
    .wr_en_i   (do_enq),
    .wr_addr_i (enq_ptr_q),
    .wr_data_i (io.io_enq_bits_data),
    .rd_addr_i (deq_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  assign io.io_enq_ready     = enq_ready;
  assign io.io_deq_valid     = deq_valid;
  assign io.io_deq_bits_data = deq_data;
  assign io.io_count         = count;

endmodule

`default_nettype wire
